// File: rtl/fpga_rst_boot_seq.sv
// FPGA reset/boot sequencer: synchronizes straps, debounces the reset button and
// holds the MCU in reset until clock lock. Optional exit-status latch: FPGA_EXIT_LATCH_EN.
//   state     | meaning
//   LOCK_WAIT | waiting for clock lock with button released
//   HOLD      | MCU reset held for RST_HOLD_CYCLES cycles
//   RUN       | MCU released, straps latched
module fpga_rst_boot_seq #(
  parameter int DEBOUNCE_CYCLES  = 1000,
  parameter int RST_HOLD_CYCLES  = 64,
  parameter int HEARTBEAT_LENGTH = 27
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clk_locked_i,
  input  logic       rst_btn_i,
  input  logic       boot_select_i,
  input  logic       execute_from_flash_i,
  input  logic       exit_valid_i,
  input  logic       exit_value_i,
  output logic       mcu_rst_no,
  output logic       boot_select_o,
  output logic       execute_from_flash_o,
  output logic       exit_value_o,
  output logic       exit_led_o,
  output logic       rst_led_o,
  output logic       clk_led_o,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    LOCK_WAIT = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);

  logic [1:0] lock_sync_q, btn_sync_q, boot_sync_q, flash_sync_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic btn_deb_q, btn_deb_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [HEARTBEAT_LENGTH-1:0] hb_q;
  state_t state_q, state_d;
  logic mcu_rst_n_q, boot_sel_q, exec_flash_q;

  logic lock_s, btn_s;
  assign lock_s = lock_sync_q[1];
  assign btn_s  = btn_sync_q[1];

  // Debounce: counter restarts whenever the synchronized button agrees with the level.
  always_comb begin
    btn_deb_d = btn_deb_q;
    db_cnt_d  = '0;
    if (btn_s != btn_deb_q) begin
      if (db_cnt_q == DB_LAST) btn_deb_d = btn_s;
      else db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    if (!lock_s) begin
      state_d = LOCK_WAIT;
    end else if (btn_deb_q && state_q != LOCK_WAIT) begin
      state_d = LOCK_WAIT;
    end else begin
      case (state_q)
        LOCK_WAIT: begin
          if (!btn_deb_q) begin
            state_d    = HOLD;
            hold_cnt_d = '0;
          end
        end
        HOLD: begin
          if (hold_cnt_q == HOLD_LAST) state_d = RUN;
          else hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
        RUN:     state_d = RUN;
        default: state_d = LOCK_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_sync_q  <= '0;
      btn_sync_q   <= '0;
      boot_sync_q  <= '0;
      flash_sync_q <= '0;
      db_cnt_q     <= '0;
      btn_deb_q    <= 1'b0;
      hold_cnt_q   <= '0;
      hb_q         <= '0;
      state_q      <= LOCK_WAIT;
      mcu_rst_n_q  <= 1'b0;
      boot_sel_q   <= 1'b0;
      exec_flash_q <= 1'b0;
    end else begin
      lock_sync_q  <= {lock_sync_q[0], clk_locked_i};
      btn_sync_q   <= {btn_sync_q[0], rst_btn_i};
      boot_sync_q  <= {boot_sync_q[0], boot_select_i};
      flash_sync_q <= {flash_sync_q[0], execute_from_flash_i};
      db_cnt_q     <= db_cnt_d;
      btn_deb_q    <= btn_deb_d;
      hold_cnt_q   <= hold_cnt_d;
      hb_q         <= hb_q + HEARTBEAT_LENGTH'(1);
      state_q      <= state_d;
      // Registered from next state so the MCU release coincides with RUN.
      mcu_rst_n_q  <= (state_d == RUN);
      if (state_q == HOLD && state_d == RUN) begin
        boot_sel_q   <= boot_sync_q[1];
        exec_flash_q <= flash_sync_q[1];
      end
    end
  end

`ifdef FPGA_EXIT_LATCH_EN
  logic exit_val_q, exit_led_q, hold_entry;
  assign hold_entry = (state_d == HOLD) && (state_q != HOLD);

  // First exit report in RUN is kept until reset or the next HOLD entry.
  always_ff @(posedge clk_i) begin
    if (rst_i || hold_entry) begin
      exit_val_q <= 1'b0;
      exit_led_q <= 1'b0;
    end else if (state_q == RUN && exit_valid_i && !exit_led_q) begin
      exit_val_q <= exit_value_i;
      exit_led_q <= 1'b1;
    end
  end

  assign exit_value_o = exit_val_q;
  assign exit_led_o   = exit_led_q;
`else
  logic unused_exit_valid;
  assign unused_exit_valid = exit_valid_i;
  assign exit_value_o      = exit_value_i;
  assign exit_led_o        = 1'b0;
`endif

  assign mcu_rst_no           = mcu_rst_n_q;
  assign rst_led_o            = mcu_rst_n_q;
  assign boot_select_o        = boot_sel_q;
  assign execute_from_flash_o = exec_flash_q;
  assign clk_led_o            = hb_q[HEARTBEAT_LENGTH-1];
  assign state_o              = state_q;

endmodule

// File: tb/tb_fpga_rst_boot_seq.sv
// Bench for fpga_rst_boot_seq: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model. Honours FPGA_EXIT_LATCH_EN if defined.
module tb_fpga_rst_boot_seq;
  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int HB   = 5;

  logic clk = 1'b0;
  logic rst, lock, btn, boot, flash, evalid, evalue;
  logic mcu_rst_no, boot_o, flash_o, ev_o, led_o, rled_o, cled_o;
  logic [1:0] state_o;

  fpga_rst_boot_seq #(.DEBOUNCE_CYCLES(DEB), .RST_HOLD_CYCLES(HOLD), .HEARTBEAT_LENGTH(HB)) dut (
    .clk_i(clk), .rst_i(rst), .clk_locked_i(lock), .rst_btn_i(btn),
    .boot_select_i(boot), .execute_from_flash_i(flash),
    .exit_valid_i(evalid), .exit_value_i(evalue),
    .mcu_rst_no(mcu_rst_no), .boot_select_o(boot_o), .execute_from_flash_o(flash_o),
    .exit_value_o(ev_o), .exit_led_o(led_o), .rst_led_o(rled_o), .clk_led_o(cled_o),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Model: synchronizer pipelines, run length of disagreeing button samples,
  // state as 0/1/2, number of HOLD cycles already spent.
  bit m_lk1, m_lk2, m_b1, m_b2, m_s1, m_s2, m_f1, m_f2;
  bit m_deb, m_mcu, m_boot, m_flash, m_ev, m_led;
  int m_run, m_st, m_hold, m_hb;

  task automatic tick();
    int nst, nhold, nrun;
    bit ndeb, nboot, nflash, nev, nled;
    @(posedge clk);
    if (rst) begin
      {m_lk1, m_lk2, m_b1, m_b2, m_s1, m_s2, m_f1, m_f2} = '0;
      {m_deb, m_mcu, m_boot, m_flash, m_ev, m_led} = '0;
      m_run = 0; m_st = 0; m_hold = 0; m_hb = 0;
    end else begin
      ndeb = m_deb; nrun = 0;
      if (m_b2 != m_deb) begin
        nrun = m_run + 1;
        if (nrun == DEB) begin ndeb = m_b2; nrun = 0; end
      end
      nst = m_st; nhold = m_hold; nboot = m_boot; nflash = m_flash;
      if (!m_lk2) nst = 0;
      else if (m_deb && m_st != 0) nst = 0;
      else if (m_st == 0) begin
        if (!m_deb) begin nst = 1; nhold = 0; end
      end else if (m_st == 1) begin
        if (m_hold == HOLD - 1) begin nst = 2; nboot = m_s2; nflash = m_f2; end
        else nhold = m_hold + 1;
      end
      nev = m_ev; nled = m_led;
      if (nst == 1 && m_st != 1) begin nev = 0; nled = 0; end
      else if (m_st == 2 && evalid && !m_led) begin nev = evalue; nled = 1; end
      m_lk2 = m_lk1; m_lk1 = lock; m_b2 = m_b1; m_b1 = btn;
      m_s2 = m_s1; m_s1 = boot; m_f2 = m_f1; m_f1 = flash;
      m_deb = ndeb; m_run = nrun; m_st = nst; m_hold = nhold;
      m_boot = nboot; m_flash = nflash; m_ev = nev; m_led = nled;
      m_mcu = (nst == 2);
      m_hb = (m_hb + 1) % (1 << HB);
    end
    #1;
  endtask

  function automatic logic [8:0] mexp();
    logic ev, led;
`ifdef FPGA_EXIT_LATCH_EN
    ev = m_ev; led = m_led;
`else
    ev = evalue; led = 1'b0;
`endif
    return {m_mcu, m_boot, m_flash, ev, led, m_mcu, 1'((m_hb >> (HB - 1)) & 1), 2'(m_st)};
  endfunction

  function automatic logic [8:0] actual();
    return {mcu_rst_no, boot_o, flash_o, ev_o, led_o, rled_o, cled_o, state_o};
  endfunction

  task automatic do_reset(input bit b, input bit f);
    rst = 1; lock = 0; btn = 0; boot = b; flash = f; evalid = 0; evalue = 0;
    tick(); tick();
    rst = 0;
  endtask

  task automatic power_up();
    lock = 1;
    repeat (HOLD + 3) tick();
  endtask

  task automatic test_reset();
    rst = 1; lock = 1; btn = 1; boot = 1; flash = 1; evalid = 1; evalue = 0;
    tick(); tick();
    n_chk++; if (actual() !== 9'd0) $display("FAIL reset_outputs: got %b want %b", actual(), 9'd0); else n_pass++;
    n_chk++; if (actual() !== mexp()) $display("FAIL reset_model: got %b want %b", actual(), mexp()); else n_pass++;
  endtask

  task automatic test_power_up();
    do_reset(0, 0);
    lock = 1;
    for (int c = 1; c <= HOLD + 3; c++) begin
      tick();
      if (c == 2) begin n_chk++; if (state_o !== 2'd0) $display("FAIL pu_state_c2: got %0d want 0", state_o); else n_pass++; end
      if (c == 3) begin n_chk++; if (state_o !== 2'd1) $display("FAIL pu_state_c3: got %0d want 1", state_o); else n_pass++; end
      if (c == HOLD + 2) begin n_chk++; if (mcu_rst_no !== 1'b0) $display("FAIL pu_mcu_c10: got %b want 0", mcu_rst_no); else n_pass++; end
      if (c == HOLD + 3) begin
        n_chk++; if ({mcu_rst_no, rled_o, state_o} !== 4'b1110) $display("FAIL pu_run_c11: got %b want 1110", {mcu_rst_no, rled_o, state_o}); else n_pass++;
      end
    end
  endtask

  task automatic test_strap();
    do_reset(1, 0);
    power_up();
    boot = 0; flash = 1;
    repeat (20) tick();
    n_chk++; if ({boot_o, flash_o} !== 2'b10) $display("FAIL strap_run_hold: got %b want 10", {boot_o, flash_o}); else n_pass++;
    lock = 0;
    repeat (6) tick();
    n_chk++; if ({boot_o, flash_o, state_o} !== 4'b1000) $display("FAIL strap_lockwait_hold: got %b want 1000", {boot_o, flash_o, state_o}); else n_pass++;
    power_up();
    n_chk++; if ({boot_o, flash_o, mcu_rst_no} !== 3'b011) $display("FAIL strap_recapture: got %b want 011", {boot_o, flash_o, mcu_rst_no}); else n_pass++;
  endtask

  task automatic test_debounce();
    do_reset(0, 0);
    power_up();
    // Two 3-cycle glitches separated by one idle cycle must both be rejected.
    btn = 1; repeat (3) tick();
    btn = 0; tick();
    btn = 1; repeat (3) tick();
    btn = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      n_chk++; if (mcu_rst_no !== 1'b1) $display("FAIL db_glitch_c%0d: got %b want 1", c, mcu_rst_no); else n_pass++;
    end
    btn = 1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 6) begin n_chk++; if (mcu_rst_no !== 1'b1) $display("FAIL db_press_c6: got %b want 1", mcu_rst_no); else n_pass++; end
      if (c == 7) begin n_chk++; if ({mcu_rst_no, state_o} !== 3'b000) $display("FAIL db_press_c7: got %b want 000", {mcu_rst_no, state_o}); else n_pass++; end
    end
    btn = 0;
    for (int c = 1; c <= HOLD + 7; c++) begin
      tick();
      if (c == 6) begin n_chk++; if (state_o !== 2'd0) $display("FAIL db_release_c6: got %0d want 0", state_o); else n_pass++; end
      if (c == 7) begin n_chk++; if (state_o !== 2'd1) $display("FAIL db_release_c7: got %0d want 1", state_o); else n_pass++; end
      if (c == HOLD + 7) begin n_chk++; if (mcu_rst_no !== 1'b1) $display("FAIL db_rerun: got %b want 1", mcu_rst_no); else n_pass++; end
    end
  endtask

  task automatic test_lock_loss();
    do_reset(0, 0);
    lock = 1;
    repeat (8) tick();
    n_chk++; if (state_o !== 2'd1) $display("FAIL ll_in_hold: got %0d want 1", state_o); else n_pass++;
    lock = 0;
    for (int c = 9; c <= 11; c++) begin
      tick();
      if (c == 10) begin n_chk++; if (state_o !== 2'd1) $display("FAIL ll_c10: got %0d want 1", state_o); else n_pass++; end
      if (c == 11) begin n_chk++; if ({mcu_rst_no, state_o} !== 3'b000) $display("FAIL ll_c11: got %b want 000", {mcu_rst_no, state_o}); else n_pass++; end
    end
    lock = 1;
    for (int c = 1; c <= HOLD + 3; c++) begin
      tick();
      if (c == HOLD + 2) begin n_chk++; if ({mcu_rst_no, state_o} !== 3'b001) $display("FAIL ll_relock_c10: got %b want 001", {mcu_rst_no, state_o}); else n_pass++; end
      if (c == HOLD + 3) begin n_chk++; if (mcu_rst_no !== 1'b1) $display("FAIL ll_relock_c11: got %b want 1", mcu_rst_no); else n_pass++; end
    end
  endtask

  task automatic test_exit();
`ifdef FPGA_EXIT_LATCH_EN
    do_reset(0, 0);
    power_up();
    evalid = 1; evalue = 1; tick();
    evalid = 0; evalue = 0; tick();
    n_chk++; if ({ev_o, led_o} !== 2'b11) $display("FAIL exit_latch: got %b want 11", {ev_o, led_o}); else n_pass++;
    evalid = 1; evalue = 0; tick();
    evalid = 0; repeat (3) tick();
    n_chk++; if ({ev_o, led_o} !== 2'b11) $display("FAIL exit_sticky: got %b want 11", {ev_o, led_o}); else n_pass++;
    btn = 1; repeat (10) tick();
    n_chk++; if ({ev_o, led_o, state_o} !== 4'b1100) $display("FAIL exit_lockwait: got %b want 1100", {ev_o, led_o, state_o}); else n_pass++;
    btn = 0; repeat (7) tick();
    n_chk++; if ({ev_o, led_o, state_o} !== 4'b0001) $display("FAIL exit_hold_clear: got %b want 0001", {ev_o, led_o, state_o}); else n_pass++;
`else
    for (int i = 0; i < 4; i++) begin
      logic v;
      v = 1'($urandom_range(0, 1));
      evalid = 1; evalue = v; #1;
      n_chk++; if ({ev_o, led_o} !== {v, 1'b0}) $display("FAIL exit_passthru_%0d: got %b want %b", i, {ev_o, led_o}, {v, 1'b0}); else n_pass++;
    end
    evalid = 0; evalue = 0;
`endif
  endtask

  task automatic test_mid_run_reset();
    do_reset(1, 1);
    power_up();
    evalid = 1; evalue = 1; tick();
    evalid = 0; evalue = 0;
    btn = 1; repeat (2) tick();
    rst = 1; tick();
    n_chk++; if (actual() !== 9'd0) $display("FAIL midrun_reset: got %b want %b", actual(), 9'd0); else n_pass++;
    rst = 0; btn = 0;
  endtask

  task automatic test_random();
    do_reset(0, 0);
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (lock) begin if ($urandom_range(0, 249) == 0) lock = 0; end
      else if ($urandom_range(0, 9) == 0) lock = 1;
      if (!btn) begin if ($urandom_range(0, 59) == 0) btn = 1; end
      else if ($urandom_range(0, 3) == 0) btn = 0;
      if ($urandom_range(0, 19) == 0) boot = ~boot;
      if ($urandom_range(0, 19) == 0) flash = ~flash;
      evalid = ($urandom_range(0, 9) == 0);
      evalue = 1'($urandom_range(0, 1));
      tick();
      n_chk++; if (actual() !== mexp()) $display("FAIL random_c%0d: got %b want %b", c, actual(), mexp()); else n_pass++;
    end
    rst = 0;
  endtask

  initial begin
    rst = 1; lock = 0; btn = 0; boot = 0; flash = 0; evalid = 0; evalue = 0;
    test_reset();
    test_power_up();
    test_strap();
    test_debounce();
    test_lock_loss();
    test_exit();
    test_mid_run_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
